// File: rtl/priority_codec_pipe.sv
// rtl/priority_codec_pipe.sv - two-stage leading zero/one counter with valid/ready handshake
// Define PCODEC_DATA_PASS_EN to carry the scanned word alongside the count on data_o.
module priority_codec_pipe #(
  parameter int WIDTH = 26,
  parameter int GROUP = 4,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] data_i,
  input  logic             mode_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [CNT_W-1:0] count_o,
`ifdef PCODEC_DATA_PASS_EN
  output logic             all_o,
  output logic [WIDTH-1:0] data_o
`else
  output logic             all_o
`endif
);

  localparam int NSEG  = (WIDTH + GROUP - 1) / GROUP;
  localparam int PW    = NSEG * GROUP;
  localparam int SEG_W = $clog2(GROUP + 1);

  logic                       s1_valid;
  logic                       s1_adv;
  logic [NSEG-1:0][SEG_W-1:0] seg_lz;
  logic [NSEG-1:0][SEG_W-1:0] s1_lz;
  logic [NSEG-1:0]            seg_zero;
  logic [NSEG-1:0]            s1_zero;
  logic [PW-1:0]              xp;
  logic                       hit;
  logic [CNT_W-1:0]           sum;
  logic                       stop;

  assign s1_adv  = !valid_o || ready_i;
  assign ready_o = !s1_valid || s1_adv;

  // Word is padded below the LSB with ones so a short last segment stops at its real bits.
  always_comb begin
    xp = '1;
    xp[PW-1 -: WIDTH] = mode_i ? ~data_i : data_i;
    hit = 1'b0;
    for (int s = 0; s < NSEG; s++) begin
      seg_lz[s]   = '0;
      seg_zero[s] = ~|xp[PW-1-s*GROUP -: GROUP];
      hit         = 1'b0;
      for (int b = 0; b < GROUP; b++) begin
        if (!hit) begin
          if (xp[PW-1-s*GROUP-b]) hit = 1'b1;
          else                    seg_lz[s] = seg_lz[s] + SEG_W'(1);
        end
      end
    end
  end

  always_comb begin
    sum  = '0;
    stop = 1'b0;
    for (int s = 0; s < NSEG; s++) begin
      if (!stop) begin
        sum  = sum + CNT_W'(s1_lz[s]);
        stop = !s1_zero[s];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_lz    <= '0;
      s1_zero  <= '0;
    end else if (ready_o) begin
      s1_valid <= valid_i;
      if (valid_i) begin
        s1_lz   <= seg_lz;
        s1_zero <= seg_zero;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_o <= 1'b0;
      count_o <= '0;
      all_o   <= 1'b0;
    end else if (s1_adv) begin
      valid_o <= s1_valid;
      if (s1_valid) begin
        count_o <= sum;
        all_o   <= (sum == CNT_W'(WIDTH));
      end
    end
  end

`ifdef PCODEC_DATA_PASS_EN
  logic [WIDTH-1:0] s1_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_data <= '0;
    end else if (ready_o && valid_i) begin
      s1_data <= data_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_o <= '0;
    end else if (s1_adv && s1_valid) begin
      data_o <= s1_data;
    end
  end
`endif

endmodule

// File: tb/tb_priority_codec_pipe.sv
// tb/tb_priority_codec_pipe.sv - directed and randomised checks of priority_codec_pipe at WIDTH 26, 8 and 32
module tb_priority_codec_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  int          total = 0;
  int          bad = 0;
  logic        vin  [3];
  logic        mode [3];
  logic        rdy  [3];
  logic [31:0] din  [3];

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  // Reference: walk from the top bit and count bits equal to the mode digit.
  function automatic int lead(input logic [31:0] d, input logic m, input int w);
    int n = 0;
    for (int i = w - 1; i >= 0; i--) begin
      if (d[i] != m) break;
      n++;
    end
    return n;
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_inst
    localparam int W  = (g == 0) ? 26 : (g == 1) ? 8 : 32;
    localparam int CW = $clog2(W + 1);

    logic          ro;
    logic          vo;
    logic          all;
    logic [CW-1:0] cnt;
    logic [31:0]   qd [$];
    logic          qm [$];
    logic [31:0]   ed;
    logic          em;
    int            n;
    logic          hold = 1'b0;
    logic [CW-1:0] hcnt;
    logic          hall;
`ifdef PCODEC_DATA_PASS_EN
    logic [W-1:0]  dout;
    logic [W-1:0]  hdat;
`endif

    priority_codec_pipe #(.WIDTH(W), .GROUP(4)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .valid_i(vin[g]),
      .ready_o(ro),
      .data_i (din[g][W-1:0]),
      .mode_i (mode[g]),
      .valid_o(vo),
      .ready_i(rdy[g]),
      .count_o(cnt),
`ifdef PCODEC_DATA_PASS_EN
      .data_o (dout),
`endif
      .all_o  (all)
    );

    always @(negedge clk) begin
      if (!rst_n) begin
        qd.delete();
        qm.delete();
        hold = 1'b0;
      end else begin
        if (hold) begin
          chk($sformatf("hold_valid%0d", g), vo, 1);
          chk($sformatf("hold_count%0d", g), cnt, hcnt);
          chk($sformatf("hold_all%0d", g), all, hall);
`ifdef PCODEC_DATA_PASS_EN
          chk($sformatf("hold_data%0d", g), dout, hdat);
`endif
        end
        if (vo && rdy[g]) begin
          if (qd.size() == 0) begin
            chk($sformatf("spurious_out%0d", g), 1, 0);
          end else begin
            ed = qd.pop_front();
            em = qm.pop_front();
            n  = lead(ed, em, W);
            chk($sformatf("count%0d", g), cnt, n);
            chk($sformatf("all%0d", g), all, (n == W));
`ifdef PCODEC_DATA_PASS_EN
            chk($sformatf("data%0d", g), dout, ed[W-1:0]);
`endif
          end
        end
        hold = vo && !rdy[g];
        hcnt = cnt;
        hall = all;
`ifdef PCODEC_DATA_PASS_EN
        hdat = dout;
`endif
        if (vin[g] && ro) begin
          qd.push_back(din[g]);
          qm.push_back(mode[g]);
        end
      end
    end
  end

  task automatic send(input logic [31:0] d, input logic m, input int ec, input logic ea, input string nm);
    @(posedge clk); #1;
    vin[0] = 1'b1; din[0] = d; mode[0] = m;
    @(posedge clk); #1;
    vin[0] = 1'b0;
    @(negedge clk);
    chk({nm, "_early"}, g_inst[0].vo, 0);
    @(posedge clk);
    @(negedge clk);
    chk({nm, "_valid"}, g_inst[0].vo, 1);
    chk({nm, "_count"}, g_inst[0].cnt, ec);
    chk({nm, "_all"}, g_inst[0].all, ea);
  endtask

  logic [31:0] r;

  initial begin
    for (int i = 0; i < 3; i++) begin
      vin[i] = 1'b0; mode[i] = 1'b0; rdy[i] = 1'b1; din[i] = '0;
    end
    vin[0] = 1'b1; din[0] = 32'h155;
    repeat (2) @(negedge clk);
    chk("rst_valid", g_inst[0].vo, 0);
    chk("rst_count", g_inst[0].cnt, 0);
    chk("rst_all", g_inst[0].all, 0);
    @(posedge clk); #1;
    rst_n = 1'b1; vin[0] = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", g_inst[0].ro, 1);
    chk("no_ghost", g_inst[0].vo, 0);

    chk("model_lz25", lead(32'h0000001, 1'b0, 26), 25);
    chk("model_lo25", lead(32'h3FFFFFE, 1'b1, 26), 25);
    chk("model_all26", lead(32'h3FFFFFF, 1'b1, 26), 26);

    for (int k = 25; k >= 0; k--) send(32'h1 << k, 1'b0, 25 - k, 1'b0, $sformatf("sweep%0d", k));
    send(32'h3FFFFFF, 1'b1, 26, 1'b1, "ones_m1");
    send(32'h0000000, 1'b0, 26, 1'b1, "zeros_m0");
    send(32'h2000000, 1'b1, 1, 1'b0, "msb_m1");
    send(32'h0200000, 1'b0, 4, 1'b0, "seg_4");
    send(32'h0100000, 1'b0, 5, 1'b0, "seg_5");
    send(32'h3FFFFFE, 1'b1, 25, 1'b0, "m1_25");
    send(32'h3FFFFFF, 1'b0, 0, 1'b0, "ones_m0");

    // Backpressure: ready_i low while inputs keep coming.
    @(posedge clk); #1;
    rdy[0] = 1'b0; vin[0] = 1'b1; din[0] = 32'h0001234; mode[0] = 1'b0;
    @(negedge clk);
    chk("bp_ready0", g_inst[0].ro, 1);
    @(posedge clk); #1;
    din[0] = 32'h3FF0000;
    @(negedge clk);
    chk("bp_ready1", g_inst[0].ro, 1);
    @(posedge clk); #1;
    din[0] = 32'h0000001;
    @(negedge clk);
    chk("bp_ready_drop", g_inst[0].ro, 0);
    chk("bp_head", g_inst[0].cnt, 13);
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
      chk("bp_stall_ready", g_inst[0].ro, 0);
      chk("bp_stall_count", g_inst[0].cnt, 13);
    end
    @(posedge clk); #1;
    rdy[0] = 1'b1;
    @(negedge clk);
    chk("bp_ready_back", g_inst[0].ro, 1);
    @(posedge clk); #1;
    vin[0] = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("bp_drained", g_inst[0].qd.size(), 0);

    // Reset with two transactions in flight.
    @(posedge clk); #1;
    vin[0] = 1'b1; din[0] = 32'h00000F0;
    @(posedge clk); #1;
    din[0] = 32'h0000F00;
    @(posedge clk); #1;
    vin[0] = 1'b0;
    chk("pre_rst_valid", g_inst[0].vo, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", g_inst[0].vo, 0);
    chk("mid_rst_count", g_inst[0].cnt, 0);
    chk("mid_rst_all", g_inst[0].all, 0);
`ifdef PCODEC_DATA_PASS_EN
    chk("mid_rst_data", g_inst[0].dout, 0);
`endif
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid_rst_ready", g_inst[0].ro, 1);
    repeat (3) begin
      @(negedge clk);
      chk("no_stale", g_inst[0].vo, 0);
    end

    for (int c = 0; c < 1500; c++) begin
      @(posedge clk); #1;
      for (int i = 0; i < 3; i++) begin
        vin[i]  = ($urandom_range(0, 99) < 65);
        rdy[i]  = ($urandom_range(0, 99) < 70);
        mode[i] = 1'($urandom_range(0, 1));
        r = $urandom >> $urandom_range(0, 31);
        if ($urandom_range(0, 5) == 0) r = '0;
        din[i] = mode[i] ? ~r : r;
      end
    end
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      vin[i] = 1'b0; rdy[i] = 1'b1;
    end
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("drain26", g_inst[0].qd.size(), 0);
    chk("drain8", g_inst[1].qd.size(), 0);
    chk("drain32", g_inst[2].qd.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
